regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the core integer register file.
- Configurable data width, depth and read-port count; optional hardwired zero register and write-to-read bypass.
- Adds a post-reset hardware clear sequencer so the array can be mapped to RAM with no reset.
- Adds a per-register busy scoreboard so the issue stage can detect RAW hazards on in-flight destinations.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; need not be a power of two.
- NUM_RD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, if 1 then register 0 reads as 0, and writes or allocs to it are ignored.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to matching read ports.
- AW, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- i_CLK  input  1  clock, rising edge.
- i_RST_N  input  1  asynchronous active-low reset.
- o_READY  output  1  high once the clear sequence has completed.
- i_WE  input  1  write enable (writeback).
- i_RD_PTR  input  AW  write destination index.
- i_RD  input  XLEN  write data.
- i_ALLOC_VALID  input  1  reserve a destination at issue (set busy).
- i_ALLOC_PTR  input  AW  index to reserve.
- i_FLUSH  input  1  clear all busy bits (pipeline flush).
- i_RS_PTR  input  NUM_RD*AW  read indices; port k uses bits [k*AW +: AW].
- o_RS  output  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- o_RS_BUSY  output  NUM_RD  busy flag of each read port's register.

Behaviour:
- States: CLEAR and RUN.
- Reset (async assert, at any time, including mid-clear or mid-run):
  - State goes to CLEAR, clr_ptr goes to 0, all busy bits go to 0.
  - o_READY=0, o_RS=0 and o_RS_BUSY=0 immediately.
  - The array contents themselves are not reset.
- CLEAR:
  - Each rising edge writes 0 to entry clr_ptr, then clr_ptr increments.
  - On the edge that writes entry DEPTH-1, the state moves to RUN.
  - o_READY rises after exactly DEPTH edges following reset deassertion.
  - i_WE, i_ALLOC_VALID and i_FLUSH are ignored.
  - All o_RS and o_RS_BUSY read 0.
- RUN: remains in RUN until the next reset. o_READY=1.
- Effective write: we = READY & i_WE & (i_RD_PTR<DEPTH) & !(ZERO_REG & i_RD_PTR==0). The array is updated on the rising edge.
- Effective alloc: al = READY & i_ALLOC_VALID & (i_ALLOC_PTR<DEPTH) & !(ZERO_REG & i_ALLOC_PTR==0).
- Read port k, combinational, with priority high to low:
  1. Not READY: data 0, busy 0.
  2. ptr>=DEPTH, or ZERO_REG and ptr==0: data 0, busy 0.
  3. BYPASS and we and i_RD_PTR==ptr: data i_RD, busy 0.
  4. Otherwise: data array[ptr], busy busy[ptr].
- Read ports are fully independent; any number may address the same register.
- Scoreboard update, on the rising edge:
  - i_FLUSH=1 (in RUN): all busy bits go to 0. Flush overrides any alloc in the same cycle. A write in that cycle still updates the data.
  - Otherwise, we clears busy[i_RD_PTR], then al sets busy[i_ALLOC_PTR].
  - Alloc and write to the same index in one cycle: busy ends at 1 (the new producer wins) and the data is written.
  - Alloc to an already-busy register: stays 1, no error.
  - Write to a non-busy register: data is written, busy stays 0.
- With BYPASS=0, a same-cycle write is visible on reads only from the next cycle; busy reflects the pre-edge state.
- No internal storage of read pointers: read latency is 0, write-to-read latency is 0 with BYPASS and 1 cycle without.

Test Plan:
- Reset clear: preload entries 5 and 31 with 0xDEADBEEF, pulse i_RST_N low mid-run, release -> o_READY low for 32 cycles, high on cycle 32; reads of 5 and 31 return 0; i_WE held high during CLEAR has no effect.
- Bypass (BYPASS=1): write 0x12345678 to r7 with both read ports on r7 in the same cycle -> both o_RS=0x12345678 and busy=0 that cycle; next cycle the array-path read also returns 0x12345678. With BYPASS=0, the same-cycle read returns the old value.
- Zero register: write 0xFFFFFFFF and alloc to r0 -> reads of r0 return 0 and busy 0 forever. With ZERO_REG=0, r0 reads back 0xFFFFFFFF.
- Scoreboard: alloc r3; next cycle read r3 -> busy=1. Write r3=0xA5 -> same cycle busy=0 and data 0xA5 via bypass. Alloc and write r3 in the same cycle -> busy=1 after the edge, data 0xA5.
- Flush: alloc r1, r2, r9, then assert i_FLUSH together with alloc r4 and write r9=0x55 -> after the edge all busy=0 including r4, and r9=0x55.
- Parametrisation: DEPTH=24, NUM_RD=3, XLEN=64 -> clear takes 24 cycles; ptr 30 reads 0 and busy 0; a write to ptr 30 changes nothing; three ports read r1, r2 and r23 independently with correct 64-bit data.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised integer register file with post-reset clear sequencer
// and per-register busy scoreboard for RAW hazard detection.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                   i_CLK,
  input  logic                   i_RST_N,
  output logic                   o_READY,
  input  logic                   i_WE,
  input  logic [AW-1:0]          i_RD_PTR,
  input  logic [XLEN-1:0]        i_RD,
  input  logic                   i_ALLOC_VALID,
  input  logic [AW-1:0]          i_ALLOC_PTR,
  input  logic                   i_FLUSH,
  input  logic [NUM_RD*AW-1:0]   i_RS_PTR,
  output logic [NUM_RD*XLEN-1:0] o_RS,
  output logic [NUM_RD-1:0]      o_RS_BUSY
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  state_t           state;
  logic [AW-1:0]    clr_ptr;
  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             we;
  logic             al;

  function automatic logic ok_ptr(input logic [AW-1:0] p);
    return ({1'b0, p} < DEPTH_W) &&
           !((ZERO_REG != 0) && (p == '0));
  endfunction

  assign we = o_READY & i_WE & ok_ptr(i_RD_PTR);
  assign al = o_READY & i_ALLOC_VALID & ok_ptr(i_ALLOC_PTR);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      o_READY <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST) begin
        state   <= RUN;
        o_READY <= 1'b1;
      end
    end
  end

  // No reset on the array so it can map onto plain RAM.
  always_ff @(posedge i_CLK) begin
    if (!o_READY)
      mem[clr_ptr] <= '0;
    else if (we)
      mem[i_RD_PTR] <= i_RD;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      busy <= '0;
    end else if (o_READY) begin
      if (i_FLUSH) begin
        busy <= '0;
      end else begin
        if (we) busy[i_RD_PTR] <= 1'b0;
        if (al) busy[i_ALLOC_PTR] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ptr;
    ptr       = '0;
    o_RS      = '0;
    o_RS_BUSY = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ptr = i_RS_PTR[k*AW +: AW];
      if (!o_READY || !ok_ptr(ptr)) begin
        o_RS[k*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && we &&
                   (i_RD_PTR == ptr)) begin
        o_RS[k*XLEN +: XLEN] = i_RD;
      end else begin
        o_RS[k*XLEN +: XLEN] = mem[ptr];
        o_RS_BUSY[k]         = busy[ptr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default config plus a
// 24-deep, 3-port, 64-bit, no-zero, no-bypass config.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         we, al, fl;
  logic [4:0]   wp, ap;
  logic [63:0]  wd;
  logic [4:0]   p [3];

  logic         ready_a, ready_b;
  logic [63:0]  rs_a;
  logic [191:0] rs_b;
  logic [1:0]   busy_a;
  logic [2:0]   busy_b;
  logic [9:0]   ptr_a;
  logic [14:0]  ptr_b;

  assign ptr_a = {p[1], p[0]};
  assign ptr_b = {p[2], p[1], p[0]};

  regfile_mp #(
    .XLEN(32), .DEPTH(32), .NUM_RD(2),
    .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .i_CLK(clk), .i_RST_N(rst_n), .o_READY(ready_a),
    .i_WE(we), .i_RD_PTR(wp), .i_RD(wd[31:0]),
    .i_ALLOC_VALID(al), .i_ALLOC_PTR(ap), .i_FLUSH(fl),
    .i_RS_PTR(ptr_a), .o_RS(rs_a), .o_RS_BUSY(busy_a)
  );

  regfile_mp #(
    .XLEN(64), .DEPTH(24), .NUM_RD(3),
    .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .i_CLK(clk), .i_RST_N(rst_n), .o_READY(ready_b),
    .i_WE(we), .i_RD_PTR(wp), .i_RD(wd),
    .i_ALLOC_VALID(al), .i_ALLOC_PTR(ap), .i_FLUSH(fl),
    .i_RS_PTR(ptr_b), .o_RS(rs_b), .o_RS_BUSY(busy_b)
  );

  int          depth [2] = '{32, 24};
  int          nrd   [2] = '{2, 3};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [63:0] msk   [2] = '{64'h0000_0000_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] mm [2][32];
  bit          mb [2][32];
  int          cnt [2];

  typedef struct {
    int          dut;
    int          port;
    logic [63:0] d;
    bit          b;
  } exp_t;

  exp_t q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic bit mrdy(int d);
    return cnt[d] >= depth[d];
  endfunction

  function automatic bit okp(int d, int x);
    return (x < depth[d]) && !(zr[d] && x == 0);
  endfunction

  function automatic bit mwe(int d);
    return mrdy(d) && we && okp(d, int'(wp));
  endfunction

  function automatic bit mal(int d);
    return mrdy(d) && al && okp(d, int'(ap));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      for (int i = 0; i < 32; i++) mb[d][i] = 1'b0;
    end
  endtask

  task automatic chk_rst();
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 ||
        rs_a !== '0 || rs_b !== '0 ||
        busy_a !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL reset state t=%0t rdy=%b%b busy=%b %b",
               $time, ready_a, ready_b, busy_a, busy_b);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e = '{d, -1, 64'd0, mrdy(d)};
      q.push_back(e);
      for (int k = 0; k < nrd[d]; k++) begin
        e = '{d, k, 64'd0, 1'b0};
        if (mrdy(d) && okp(d, int'(p[k]))) begin
          if (byp[d] && mwe(d) && wp == p[k]) begin
            e.d = wd & msk[d];
          end else begin
            e.d = mm[d][p[k]];
            e.b = mb[d][p[k]];
          end
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic model_edge();
    bit w, a;
    for (int d = 0; d < 2; d++) begin
      w = mwe(d);
      a = mal(d);
      if (!mrdy(d)) begin
        mm[d][cnt[d]] = 64'd0;
        cnt[d]++;
      end else begin
        if (w) mm[d][wp] = wd & msk[d];
        if (fl) begin
          for (int i = 0; i < 32; i++) mb[d][i] = 1'b0;
        end else begin
          if (w) mb[d][wp] = 1'b0;
          if (a) mb[d][ap] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    #1 push_exp();
    if (!rst_n) chk_rst();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic wait_rdy(input int n);
    int i;
    i = 0;
    while (!(ready_a === 1'b1 && ready_b === 1'b1) && i < n) begin
      step();
      i++;
    end
    checks++;
    if (!(ready_a === 1'b1 && ready_b === 1'b1)) begin
      errors++;
      $display("FAIL ready wait expired t=%0t rdy=%b%b",
               $time, ready_a, ready_b);
    end
  endtask

  task automatic set(input bit w, input int wpi,
                     input logic [63:0] wdi, input bit a,
                     input int api, input bit f,
                     input int p0, input int p1,
                     input int p2);
    we   = w;
    wp   = 5'(wpi);
    wd   = wdi;
    al   = a;
    ap   = 5'(api);
    fl   = f;
    p[0] = 5'(p0);
    p[1] = 5'(p1);
    p[2] = 5'(p2);
  endtask

  task automatic rd(input int p0, input int p1, input int p2);
    set(0, 0, 64'd0, 0, 0, 0, p0, p1, p2);
    step();
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] ad;
    bit          ab;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.port < 0) begin
        ad = 64'd0;
        ab = (e.dut == 0) ? ready_a : ready_b;
      end else if (e.dut == 0) begin
        ad = {32'd0, rs_a[e.port*32 +: 32]};
        ab = busy_a[e.port];
      end else begin
        ad = rs_b[e.port*64 +: 64];
        ab = busy_b[e.port];
      end
      checks++;
      if (ad !== e.d || ab !== e.b) begin
        errors++;
        $display("FAIL dut%0d port%0d t=%0t got d=%h b=%b exp d=%h b=%b",
                 e.dut, e.port, $time, ad, ab, e.d, e.b);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) mm[d][i] = 64'd0;
    model_reset();
    rst_n = 1'b0;
    set(0, 0, 64'd0, 0, 0, 0, 5, 31, 23);
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    wait_rdy(40);

    set(1, 5, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 5, 31, 23);
    step();
    set(1, 31, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 5, 31, 23);
    step();
    set(1, 23, 64'hCAFE_0000_DEAD_BEEF, 1, 5, 0, 5, 31, 23);
    step();
    rd(5, 31, 23);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    set(1, 5, 64'h1111_2222_3333_4444, 1, 5, 1, 5, 31, 23);
    wait_rdy(40);
    rd(5, 31, 23);

    set(1, 7, 64'h0000_0000_1234_5678, 0, 0, 0, 7, 7, 7);
    step();
    rd(7, 7, 7);

    set(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0);
    step();
    repeat (3) rd(0, 0, 0);

    set(0, 0, 64'd0, 1, 3, 0, 3, 3, 3);
    step();
    rd(3, 3, 3);
    set(1, 3, 64'h0000_0000_0000_00A5, 0, 0, 0, 3, 3, 3);
    step();
    set(1, 3, 64'h0000_0000_0000_00A5, 1, 3, 0, 3, 3, 3);
    step();
    rd(3, 3, 3);

    set(0, 0, 64'd0, 1, 1, 0, 1, 2, 9);
    step();
    set(0, 0, 64'd0, 1, 2, 0, 1, 2, 9);
    step();
    set(0, 0, 64'd0, 1, 9, 0, 1, 2, 9);
    step();
    rd(1, 2, 9);
    set(1, 9, 64'h0000_0000_0000_0055, 1, 4, 1, 1, 2, 9);
    step();
    rd(1, 2, 9);
    rd(4, 9, 3);

    set(1, 1, 64'h0101_0101_A1A1_A1A1, 0, 0, 0, 1, 2, 23);
    step();
    set(1, 2, 64'h0202_0202_B2B2_B2B2, 0, 0, 0, 1, 2, 23);
    step();
    set(1, 23, 64'h2323_2323_C3C3_C3C3, 1, 30, 0, 1, 2, 23);
    step();
    set(1, 30, 64'h3030_3030_D0D0_D0D0, 1, 30, 0, 30, 30, 30);
    step();
    rd(1, 2, 23);
    rd(30, 30, 30);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
      set(bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 31)),
          {$urandom, $urandom},
          bit'($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 31)),
          bit'($urandom_range(0, 15) == 0),
          int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)));
      step();
    end

    rst_n = 1'b1;
    set(0, 0, 64'd0, 0, 0, 0, 0, 0, 0);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
